// File: rtl/aesl_deadlock_monitor_param_if.sv
// ---------------------------------------------------------------------------
// aesl_deadlock_monitor_param_if
//
// Status bus between a deadlock monitor and whatever drives/observes it.
// All signals are level-sampled on the rising clock edge; there is no
// valid/ready handshake on this bus.  Every input is looked at on every
// cycle, and every output is a registered status value.
//
// Signals:
//   axis_block_sigs  per-channel AXIS blocked flags          (to monitor)
//   inst_idle_sigs   per-sub-instance idle flags             (to monitor)
//   inst_block_sigs  child monitor block outputs             (to monitor)
//   clear            synchronous clear of detection state    (to monitor)
//   block            deadlock detected                       (from monitor)
//   suspect          condition present, threshold pending    (from monitor)
//   block_src        {child, masked axis} sources at detection (from monitor)
//   block_cycle      cycle-counter value at detection        (from monitor)
//   state_dbg        FSM state: 0 idle, 1 suspect, 2 blocked (from monitor)
//
// Modports: master = environment / parent side, slave = monitor side.
// ---------------------------------------------------------------------------
interface aesl_deadlock_monitor_param_if #(
   parameter int NUM_AXIS = 8,
   parameter int NUM_IDLE = 5,
   parameter int NUM_SUB  = 1,
   parameter int CNT_W    = 16
);
   logic [NUM_AXIS-1:0]         axis_block_sigs;
   logic [NUM_IDLE-1:0]         inst_idle_sigs;
   logic [NUM_SUB-1:0]          inst_block_sigs;
   logic                        clear;
   logic                        block;
   logic                        suspect;
   logic [NUM_AXIS+NUM_SUB-1:0] block_src;
   logic [CNT_W-1:0]            block_cycle;
   logic [1:0]                  state_dbg;

   modport master (
      output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
      input  block, suspect, block_src, block_cycle, state_dbg
   );

   modport slave (
      input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
      output block, suspect, block_src, block_cycle, state_dbg
   );
endinterface

// File: rtl/aesl_deadlock_monitor_param.sv
// ---------------------------------------------------------------------------
// aesl_deadlock_monitor_param
//
// Persistence-filtered deadlock monitor for co-simulation.  Watches a masked
// subset of AXIS blocked flags plus the block outputs of child monitors and
// raises block only after the blocked condition has held for THRESH
// consecutive cycles.  At detection it records which sources were blocked
// and the free-running cycle count.  Monitors chain: a child's block feeds
// one bit of its parent's inst_block_sigs.
//
// Ports:
//   clock   rising-edge clock
//   reset   synchronous active-high reset
//   mon     status bus (slave modport), see aesl_deadlock_monitor_param_if
// ---------------------------------------------------------------------------
module aesl_deadlock_monitor_param #(
   parameter int                  NUM_AXIS  = 8,
   parameter logic [NUM_AXIS-1:0] AXIS_MASK = 8'b1100_0000,
   parameter int                  NUM_IDLE  = 5,
   parameter int                  NUM_SUB   = 1,
   parameter bit                  SUB_ALL   = 1'b0,
   parameter int                  THRESH    = 4,
   parameter bit                  STICKY    = 1'b0,
   parameter int                  CNT_W     = 16
) (
   input  logic                            clock,
   input  logic                            reset,
   aesl_deadlock_monitor_param_if.slave    mon
);

   localparam int RUN_W = $clog2(THRESH + 1);
   localparam int SRC_W = NUM_AXIS + NUM_SUB;
   // Run value that, with one more qualifying cycle, completes the threshold.
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(THRESH - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_BLOCKED = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [RUN_W-1:0]   run, run_nxt;
   logic [CNT_W-1:0]   cyc;
   logic               block_q, suspect_q;
   logic [SRC_W-1:0]   src_q;
   logic [CNT_W-1:0]   cycle_q;

   logic               axis_term, sub_term, raw;
   logic [SRC_W-1:0]   src_now;
   logic               enter_blocked;

   // Blocked qualifier; an instance whose sub-instances are all idle cannot
   // be deadlocked, so the condition is suppressed in that case.
   always_comb begin
      axis_term = |(mon.axis_block_sigs & AXIS_MASK);
      sub_term  = SUB_ALL ? (&mon.inst_block_sigs) : (|mon.inst_block_sigs);
      raw       = (axis_term | sub_term) & ~(&mon.inst_idle_sigs);
      src_now   = {mon.inst_block_sigs, mon.axis_block_sigs & AXIS_MASK};
   end

   always_comb begin
      state_nxt = state;
      run_nxt   = run;
      case (state)
         ST_IDLE: begin
            if (raw) begin
               run_nxt   = RUN_W'(1);
               state_nxt = (THRESH == 1) ? ST_BLOCKED : ST_SUSPECT;
            end
         end
         ST_SUSPECT: begin
            if (raw) begin
               run_nxt = run + RUN_W'(1);
               if (run == RUN_LAST) state_nxt = ST_BLOCKED;
            end else begin
               // Any gap restarts the count from scratch.
               run_nxt   = '0;
               state_nxt = ST_IDLE;
            end
         end
         ST_BLOCKED: begin
            if (!STICKY && !raw) begin
               run_nxt   = '0;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            run_nxt   = '0;
            state_nxt = ST_IDLE;
         end
      endcase
      // clear overrides the qualifier; counting resumes on the next edge.
      if (mon.clear) begin
         run_nxt   = '0;
         state_nxt = ST_IDLE;
      end
      enter_blocked = (state_nxt == ST_BLOCKED) && (state != ST_BLOCKED);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         run       <= '0;
         cyc       <= '0;
         block_q   <= 1'b0;
         suspect_q <= 1'b0;
         src_q     <= '0;
         cycle_q   <= '0;
      end else begin
         // Timestamp saturates rather than wrapping so late detections are
         // never reported as early ones.
         if (cyc != {CNT_W{1'b1}}) cyc <= cyc + CNT_W'(1);
         state     <= state_nxt;
         run       <= run_nxt;
         block_q   <= (state_nxt == ST_BLOCKED);
         suspect_q <= (state_nxt == ST_SUSPECT);
         if (mon.clear) begin
            src_q   <= '0;
            cycle_q <= '0;
         end else if (enter_blocked) begin
            src_q   <= src_now;
            cycle_q <= cyc;
         end
      end
   end

   assign mon.block       = block_q;
   assign mon.suspect     = suspect_q;
   assign mon.block_src   = src_q;
   assign mon.block_cycle = cycle_q;
   assign mon.state_dbg   = state;

endmodule

// File: tb/tb_aesl_deadlock_monitor_param.sv
// ---------------------------------------------------------------------------
// tb_aesl_deadlock_monitor_param
//
// Four monitor configurations side by side: legacy (THRESH=1), default
// (THRESH=4), all-children (SUB_ALL=1, NUM_SUB=2) and sticky (THRESH=2).
// A reference model computes the expected outputs from the inputs seen at
// every rising edge and pushes them to one queue per instance; the values
// are popped and compared at the following falling edge.  Directed checks
// cover the specific scenarios with hand-derived constants.
// ---------------------------------------------------------------------------
module tb_aesl_deadlock_monitor_param;

   // ---------------- clock / reset ----------------
   logic clock;
   logic reset;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ---------------- DUTs ----------------
   aesl_deadlock_monitor_param_if                 if_leg ();
   aesl_deadlock_monitor_param_if                 if_main ();
   aesl_deadlock_monitor_param_if #(.NUM_SUB(2))  if_all ();
   aesl_deadlock_monitor_param_if                 if_stk ();

   aesl_deadlock_monitor_param #(.THRESH(1)) u_leg (
      .clock(clock), .reset(reset), .mon(if_leg));
   aesl_deadlock_monitor_param #(.THRESH(4)) u_main (
      .clock(clock), .reset(reset), .mon(if_main));
   aesl_deadlock_monitor_param #(.NUM_SUB(2), .SUB_ALL(1'b1), .THRESH(4)) u_all (
      .clock(clock), .reset(reset), .mon(if_all));
   aesl_deadlock_monitor_param #(.THRESH(2), .STICKY(1'b1)) u_stk (
      .clock(clock), .reset(reset), .mon(if_stk));

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0]  cnt;   // consecutive qualifying cycles, saturating at thresh
      logic        blk;
      logic        sus;
      logic [15:0] src;
      logic [15:0] bcyc;
   } mdl_t;

   function automatic mdl_t step(mdl_t m, logic rst, logic clr, logic raw,
                                 logic [15:0] src_now, int thresh, logic sticky,
                                 logic [15:0] cyc_now);
      mdl_t n;
      logic hit, nb;
      n = m;
      if (rst || clr) begin
         n = '0;
         return n;
      end
      if (raw) n.cnt = (int'(m.cnt) >= thresh) ? m.cnt : m.cnt + 8'd1;
      else     n.cnt = 8'd0;
      hit = (int'(n.cnt) >= thresh);
      nb  = sticky ? (m.blk | hit) : hit;
      if (nb && !m.blk) begin
         n.src  = src_now;
         n.bcyc = cyc_now;
      end
      n.blk = nb;
      n.sus = !nb && (n.cnt != 8'd0);
      return n;
   endfunction

   mdl_t        m_leg, m_main, m_all, m_stk;
   logic [15:0] tb_cyc;
   logic [41:0] exp_leg_q[$];
   logic [41:0] exp_main_q[$];
   logic [41:0] exp_all_q[$];
   logic [41:0] exp_stk_q[$];
   logic        raw_leg, raw_main, raw_all, raw_stk;

   initial begin
      m_leg  = '0;
      m_main = '0;
      m_all  = '0;
      m_stk  = '0;
      tb_cyc = '0;
   end

   always @(posedge clock) begin
      raw_leg  = ((|(if_leg.axis_block_sigs & 8'hC0)) | (|if_leg.inst_block_sigs))
                 & ~(&if_leg.inst_idle_sigs);
      raw_main = ((|(if_main.axis_block_sigs & 8'hC0)) | (|if_main.inst_block_sigs))
                 & ~(&if_main.inst_idle_sigs);
      raw_all  = ((|(if_all.axis_block_sigs & 8'hC0)) | (&if_all.inst_block_sigs))
                 & ~(&if_all.inst_idle_sigs);
      raw_stk  = ((|(if_stk.axis_block_sigs & 8'hC0)) | (|if_stk.inst_block_sigs))
                 & ~(&if_stk.inst_idle_sigs);
      m_leg  = step(m_leg, reset, if_leg.clear, raw_leg,
                    16'({if_leg.inst_block_sigs, if_leg.axis_block_sigs & 8'hC0}), 1, 1'b0, tb_cyc);
      m_main = step(m_main, reset, if_main.clear, raw_main,
                    16'({if_main.inst_block_sigs, if_main.axis_block_sigs & 8'hC0}), 4, 1'b0, tb_cyc);
      m_all  = step(m_all, reset, if_all.clear, raw_all,
                    16'({if_all.inst_block_sigs, if_all.axis_block_sigs & 8'hC0}), 4, 1'b0, tb_cyc);
      m_stk  = step(m_stk, reset, if_stk.clear, raw_stk,
                    16'({if_stk.inst_block_sigs, if_stk.axis_block_sigs & 8'hC0}), 2, 1'b1, tb_cyc);
      exp_leg_q.push_back(m_leg);
      exp_main_q.push_back(m_main);
      exp_all_q.push_back(m_all);
      exp_stk_q.push_back(m_stk);
      if (reset)                 tb_cyc = '0;
      else if (tb_cyc != 16'hFFFF) tb_cyc = tb_cyc + 16'd1;
   end

   task automatic cmp(input string nm, input mdl_t e, input logic blk, input logic sus,
                      input logic [15:0] src, input logic [15:0] bcyc, input logic [1:0] st);
      logic [1:0] st_exp;
      st_exp = e.blk ? 2'd2 : (e.sus ? 2'd1 : 2'd0);
      check({nm, ".block"},       32'(blk),  32'(e.blk));
      check({nm, ".suspect"},     32'(sus),  32'(e.sus));
      check({nm, ".block_src"},   32'(src),  32'(e.src));
      check({nm, ".block_cycle"}, 32'(bcyc), 32'(e.bcyc));
      check({nm, ".state"},       32'(st),   32'(st_exp));
   endtask

   always @(negedge clock) begin
      if (exp_leg_q.size() > 0)
         cmp("leg", mdl_t'(exp_leg_q.pop_front()), if_leg.block, if_leg.suspect,
             16'(if_leg.block_src), if_leg.block_cycle, if_leg.state_dbg);
      if (exp_main_q.size() > 0)
         cmp("main", mdl_t'(exp_main_q.pop_front()), if_main.block, if_main.suspect,
             16'(if_main.block_src), if_main.block_cycle, if_main.state_dbg);
      if (exp_all_q.size() > 0)
         cmp("all", mdl_t'(exp_all_q.pop_front()), if_all.block, if_all.suspect,
             16'(if_all.block_src), if_all.block_cycle, if_all.state_dbg);
      if (exp_stk_q.size() > 0)
         cmp("stk", mdl_t'(exp_stk_q.pop_front()), if_stk.block, if_stk.suspect,
             16'(if_stk.block_src), if_stk.block_cycle, if_stk.state_dbg);
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic idle_all();
      if_leg.axis_block_sigs  = '0; if_leg.inst_idle_sigs  = '0;
      if_leg.inst_block_sigs  = '0; if_leg.clear           = 1'b0;
      if_main.axis_block_sigs = '0; if_main.inst_idle_sigs = '0;
      if_main.inst_block_sigs = '0; if_main.clear          = 1'b0;
      if_all.axis_block_sigs  = '0; if_all.inst_idle_sigs  = '0;
      if_all.inst_block_sigs  = '0; if_all.clear           = 1'b0;
      if_stk.axis_block_sigs  = '0; if_stk.inst_idle_sigs  = '0;
      if_stk.inst_block_sigs  = '0; if_stk.clear           = 1'b0;
   endtask

   // Mostly-blocked random stimulus so that thresholds are actually reached.
   task automatic rand_cycle();
      if_leg.axis_block_sigs  = 8'($urandom_range(0, 255));
      if_leg.inst_idle_sigs   = ($urandom_range(0, 7) == 0) ? 5'h1F : 5'($urandom_range(0, 30));
      if_leg.inst_block_sigs  = 1'($urandom_range(0, 1));
      if_leg.clear            = ($urandom_range(0, 19) == 0);
      if_main.axis_block_sigs = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if_main.inst_idle_sigs  = ($urandom_range(0, 9) == 0) ? 5'h1F : 5'h0E;
      if_main.inst_block_sigs = ($urandom_range(0, 3) == 0);
      if_main.clear           = ($urandom_range(0, 29) == 0);
      if_all.axis_block_sigs  = ($urandom_range(0, 2) == 0) ? 8'h40 : 8'h00;
      if_all.inst_idle_sigs   = 5'($urandom_range(0, 31));
      if_all.inst_block_sigs  = ($urandom_range(0, 4) == 0) ? 2'b01 : 2'b11;
      if_all.clear            = ($urandom_range(0, 29) == 0);
      if_stk.axis_block_sigs  = ($urandom_range(0, 2) == 0) ? 8'h80 : 8'h00;
      if_stk.inst_idle_sigs   = 5'h00;
      if_stk.inst_block_sigs  = ($urandom_range(0, 3) == 0);
      if_stk.clear            = ($urandom_range(0, 7) == 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      idle_all();
      tick(3);
      check("rst.block",   32'(if_main.block),       32'd0);
      check("rst.src",     32'(if_main.block_src),   32'd0);
      check("rst.cycle",   32'(if_main.block_cycle), 32'd0);
      reset = 1'b0;

      // Legacy: single-cycle pulse sampled when the cycle counter reads 10.
      for (int i = 0; i < 40 && tb_cyc != 16'd10; i++) tick(1);
      if_leg.axis_block_sigs = 8'h40;
      tick(1);
      if_leg.axis_block_sigs = 8'h00;
      check("leg_blk_on", 32'(if_leg.block),            32'd1);
      check("leg_src",    32'(if_leg.block_src[7:0]),   32'h40);
      check("leg_cycle",  32'(if_leg.block_cycle),      32'd10);
      tick(1);
      check("leg_blk_off",  32'(if_leg.block),     32'd0);
      check("leg_src_hold", 32'(if_leg.block_src), 32'h040);

      // Persistence: 3-cycle run, 1-cycle gap, 4-cycle run.
      if_main.axis_block_sigs = 8'h80;
      tick(3);
      check("pers_sus_run1", 32'(if_main.suspect), 32'd1);
      check("pers_blk_run1", 32'(if_main.block),   32'd0);
      if_main.axis_block_sigs = 8'h00;
      tick(1);
      check("pers_gap_sus", 32'(if_main.suspect), 32'd0);
      if_main.axis_block_sigs = 8'h80;
      tick(3);
      check("pers_blk_3", 32'(if_main.block), 32'd0);
      tick(1);
      check("pers_blk_4", 32'(if_main.block), 32'd1);
      if_main.axis_block_sigs = 8'h00;
      tick(1);
      check("pers_blk_drop", 32'(if_main.block), 32'd0);

      // Mask and idle suppression.
      if_main.axis_block_sigs = 8'h3F;
      tick(6);
      check("mask_sus", 32'(if_main.suspect), 32'd0);
      check("mask_blk", 32'(if_main.block),   32'd0);
      if_main.axis_block_sigs = 8'hC0;
      if_main.inst_idle_sigs  = 5'h1F;
      tick(6);
      check("idle_sus", 32'(if_main.suspect), 32'd0);
      if_main.inst_idle_sigs = 5'h0F;
      tick(3);
      check("idle_partial_sus", 32'(if_main.suspect), 32'd1);
      tick(1);
      check("idle_partial_blk", 32'(if_main.block),     32'd1);
      check("idle_partial_src", 32'(if_main.block_src), 32'h0C0);
      if_main.axis_block_sigs = 8'h00;
      if_main.inst_idle_sigs  = 5'h00;
      tick(2);

      // All children must be blocked.
      if_all.inst_block_sigs = 2'b01;
      tick(10);
      check("all_partial_blk", 32'(if_all.block), 32'd0);
      if_all.inst_block_sigs = 2'b11;
      tick(4);
      check("all_blk",      32'(if_all.block),          32'd1);
      check("all_src_subs", 32'(if_all.block_src[9:8]), 32'd3);
      if_all.inst_block_sigs = 2'b00;
      tick(2);

      // Sticky latch and clear.
      if_stk.axis_block_sigs = 8'h80;
      tick(2);
      check("stk_blk", 32'(if_stk.block), 32'd1);
      if_stk.axis_block_sigs = 8'h00;
      tick(3);
      check("stk_hold", 32'(if_stk.block), 32'd1);
      if_stk.axis_block_sigs = 8'h80;
      if_stk.clear           = 1'b1;
      tick(1);
      check("stk_clr_blk", 32'(if_stk.block),     32'd0);
      check("stk_clr_src", 32'(if_stk.block_src), 32'd0);
      if_stk.clear = 1'b0;
      tick(1);
      check("stk_rearm_1", 32'(if_stk.block), 32'd0);
      tick(1);
      check("stk_rearm_2", 32'(if_stk.block), 32'd1);
      if_stk.axis_block_sigs = 8'h00;
      if_stk.clear           = 1'b1;
      tick(1);
      if_stk.clear = 1'b0;

      // Reset in SUSPECT with run=3, then detection timed from reset.
      if_main.axis_block_sigs = 8'h80;
      tick(3);
      check("rmid_sus", 32'(if_main.suspect), 32'd1);
      reset = 1'b1;
      tick(1);
      check("rmid_sus0", 32'(if_main.suspect),     32'd0);
      check("rmid_blk0", 32'(if_main.block),       32'd0);
      check("rmid_src0", 32'(if_main.block_src),   32'd0);
      check("rmid_cyc0", 32'(if_main.block_cycle), 32'd0);
      reset = 1'b0;
      tick(3);
      check("rmid_blk_3", 32'(if_main.block), 32'd0);
      tick(1);
      check("rmid_blk_4", 32'(if_main.block),       32'd1);
      check("rmid_cycle", 32'(if_main.block_cycle), 32'd3);
      if_main.axis_block_sigs = 8'h00;
      tick(2);

      // Random traffic checked by the model only.
      for (int i = 0; i < 400; i++) begin
         rand_cycle();
         tick(1);
      end
      idle_all();
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
